bus_test_monitor: RTL and testbench
===================================

# bus_test_monitor

Synthesizable, parametrised self-checking harness for the 6502 CPU bus, replacing simulation-only memory/checker logic so the same checks run on the FPGA and in simulation. It models a synchronous RAM with registered read data on the CPU's `AB`/`DO`/`WE`/`DI` bus. It watches CPU writes for a completion marker and enforces a cycle timeout. It compares a configurable block of result locations against expected values and streams every CPU write out through a trace FIFO for UART dump.

## Interface
Parameters:
- `ADDR_W`, 16: CPU address width.
- `RAM_AW`, 16: RAM occupies addresses 0 .. 2^RAM_AW-1; must be ≤ `ADDR_W`.
- `FILL_BYTE`, 8'hEA: read data for unmapped addresses.
- `INIT_FILE`, "": hex image loaded into RAM at elaboration; empty means RAM is filled with `FILL_BYTE`.
- `MARKER_ADDR`, 16'h8004: completion marker address.
- `MARKER_VAL`, 8'hFF: completion marker value.
- `CHECK_BASE`, 16'h8000: first checked address.
- `NUM_CHECKS`, 4: checked locations `CHECK_BASE` .. `CHECK_BASE+NUM_CHECKS-1`; range 1..64.
- `TIMEOUT`, 1000: maximum RUN cycles before the run is declared failed.
- `SETTLE_CYCLES`, 10: cycles to wait after the marker write before comparing.
- `TRACE_DEPTH`, 16: trace FIFO entries; must be a power of two ≥2.
- `CNT_W`, 32: cycle counter width.

Ports (IW = clog2(NUM_CHECKS+1)):
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `AB`  in  ADDR_W  CPU address.
- `DO`  in  8  CPU write data.
- `WE`  in  1  CPU write enable.
- `DI`  out  8  CPU read data, registered.
- `exp_vals`  in  8*NUM_CHECKS  expected values; byte k (bits 8k+7:8k) is for `CHECK_BASE+k`.
- `done`  out  1  run finished; sticky until reset.
- `pass`  out  1  valid only when `done`=1.
- `timed_out`  out  1  sticky; run ended by `TIMEOUT`.
- `fail_index`  out  IW  index of the first mismatching check; `NUM_CHECKS` on pass; all-ones on timeout.
- `cycle_count`  out  CNT_W  number of RUN cycles.
- `trace_valid`  out  1  FIFO head entry valid.
- `trace_ready`  in  1  consumer accepts the head entry.
- `trace_addr`  out  ADDR_W  address of the head entry.
- `trace_data`  out  8  data of the head entry.
- `trace_overflow`  out  1  sticky; at least one write was dropped.

## Operation
- **RAM**
  - Every cycle, `DI` <= (`AB` < 2^RAM_AW) ? mem[AB] : `FILL_BYTE`.
  - `WE`=1 with a mapped `AB` writes mem[AB] <= `DO`.
  - Read-first: a read and write to the same address in one cycle returns the old data.
  - RAM contents are not affected by `reset`.
- **Shadow registers:** one 8-bit value plus a `written` bit per check. Each write into the check range updates the value and sets the bit. Capture happens in RUN and SETTLE only; registers freeze on COMPARE entry.
- **State machine**, all states reset to RUN:
  - RUN: `cycle_count` increments each cycle and saturates at all-ones.
    - A write with `AB`==`MARKER_ADDR` and `DO`==`MARKER_VAL` goes to SETTLE.
    - Otherwise, `cycle_count`==`TIMEOUT`-1 goes to DONE with `timed_out`=1, `pass`=0, `fail_index`=all-ones.
    - If the marker write lands on the timeout cycle, the marker wins.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then goes to COMPARE. Further marker writes are ignored.
  - COMPARE: checks one index per cycle, starting at 0.
    - Mismatch, or an entry with `written`=0: go to DONE with `pass`=0 and `fail_index`=k.
    - After index `NUM_CHECKS`-1 matches: go to DONE with `pass`=1 and `fail_index`=`NUM_CHECKS`.
  - DONE: terminal state; outputs hold until reset.
- **Trace FIFO:** every cycle with `WE`=1, in any state, pushes {AB, DO}.
  - A pop happens when `trace_valid` && `trace_ready`.
  - A push when full is accepted only if a pop occurs in the same cycle. Otherwise the entry is dropped and `trace_overflow` is set.
  - A simultaneous push and pop on an empty FIFO stores the entry; the pop does nothing.
  - Pointers wrap modulo `TRACE_DEPTH`; full vs. empty is distinguished by an extra pointer bit.
- **Reset** takes effect mid-run at any state: clears state, counter, shadows, flags and FIFO. Reset values: `DI`=0, `done`=0, `pass`=0, `timed_out`=0, `fail_index`=0, `cycle_count`=0, `trace_valid`=0, `trace_overflow`=0.

## Timing
- `DI` has 1-cycle latency: `AB` sampled at edge n appears on `DI` after edge n.
- Marker write sampled at edge T: SETTLE from T+1 and COMPARE from T+1+`SETTLE_CYCLES`.
  - On a full pass, `done` rises after edge T+1+`SETTLE_CYCLES`+`NUM_CHECKS`.
  - A failure at index k asserts `done` after edge T+1+`SETTLE_CYCLES`+k.
- Timeout: `done` rises after the edge on which `cycle_count` reaches `TIMEOUT`.
- Trace: a write at edge n sets `trace_valid` after edge n when the FIFO was empty. `trace_*` are registered FIFO head outputs.

## Test plan
- Load the LDA/LDX/LDY/STA/STX/STY/ADC program at $C000 (reset vector $C000), `exp_vals`={43,24,33,42} MSB-first.
  -> `done`, `pass`=1, `fail_index`=4, `timed_out`=0.
- Same program with `exp_vals` byte 3 = 8'h44.
  -> `pass`=0, `fail_index`=3, `done` exactly 4 cycles after COMPARE entry.
- Program that never writes the marker (JMP self at $C000), `TIMEOUT`=50.
  -> `timed_out`=1, `cycle_count`=50, `fail_index`=all-ones.
- Marker written but $8002 never written.
  -> `pass`=0, `fail_index`=2.
- `trace_ready`=0 and 20 writes with `TRACE_DEPTH`=16.
  -> 16 entries retained in order, `trace_overflow`=1.
  - Full FIFO with push+pop in the same cycle -> no overflow.
- Assert `reset` during SETTLE, then re-run a passing program.
  -> all flags clear on the next edge; second run passes; RAM contents retained.

Source files
------------

// File: rtl/bus_test_monitor.sv
// bus_test_monitor: self-checking harness for a 6502 CPU bus.
// Provides the CPU's RAM (registered read data), watches for a completion
// marker write or a cycle timeout, compares a block of result locations
// against expected bytes and streams every CPU write into a trace FIFO.
module bus_test_monitor #(
  parameter int                ADDR_W        = 16,
  parameter int                RAM_AW        = 16,
  parameter logic [7:0]        FILL_BYTE     = 8'hEA,
  parameter string             INIT_FILE     = "",
  parameter logic [ADDR_W-1:0] MARKER_ADDR   = 16'h8004,
  parameter logic [7:0]        MARKER_VAL    = 8'hFF,
  parameter logic [ADDR_W-1:0] CHECK_BASE    = 16'h8000,
  parameter int                NUM_CHECKS    = 4,
  parameter int                TIMEOUT       = 1000,
  parameter int                SETTLE_CYCLES = 10,
  parameter int                TRACE_DEPTH   = 16,
  parameter int                CNT_W         = 32,
  localparam int               IW            = $clog2(NUM_CHECKS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       AB,
  input  logic [7:0]              DO,
  input  logic                    WE,
  output logic [7:0]              DI,
  input  logic [8*NUM_CHECKS-1:0] exp_vals,
  output logic                    done,
  output logic                    pass,
  output logic                    timed_out,
  output logic [IW-1:0]           fail_index,
  output logic [CNT_W-1:0]        cycle_count,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [ADDR_W-1:0]       trace_addr,
  output logic [7:0]              trace_data,
  output logic                    trace_overflow
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_t;

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int PW        = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int SW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // ---------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------
  logic [7:0]        mem [RAM_DEPTH];
  logic [7:0]        di_q;
  logic              ab_mapped;
  logic [RAM_AW-1:0] ram_idx;

  // An address is mapped when every bit above the RAM window is zero.
  assign ab_mapped = ((AB >> RAM_AW) == '0);
  assign ram_idx   = AB[RAM_AW-1:0];

  // RAM array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (WE && ab_mapped) begin
      mem[ram_idx] <= DO;
    end
  end

  // Registered read port; sees the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      di_q <= 8'h00;
    end else begin
      di_q <= ab_mapped ? mem[ram_idx] : FILL_BYTE;
    end
  end

  assign DI = di_q;

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [SW-1:0]    settle_cnt_q;
  logic [IW-1:0]    cmp_idx_q;
  logic             done_q;
  logic             pass_q;
  logic             timed_out_q;
  logic [IW-1:0]    fail_index_q;

  logic             marker_hit;
  logic             capture_en;

  assign marker_hit = WE && (AB == MARKER_ADDR) && (DO == MARKER_VAL);
  assign capture_en = (state_q == ST_RUN) || (state_q == ST_SETTLE);

  // ---------------------------------------------------------------------
  // Shadow copies of the checked locations
  // ---------------------------------------------------------------------
  logic [7:0]            shadow_q [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] written_q;
  logic [ADDR_W-1:0]     chk_off;

  // Offset of the current address from the start of the checked block;
  // wraps to a large value for addresses below the block.
  assign chk_off = AB - CHECK_BASE;

  // Capture writes into the checked block until comparison starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      written_q <= '0;
      for (int k = 0; k < NUM_CHECKS; k++) begin
        shadow_q[k] <= 8'h00;
      end
    end else if (capture_en && WE) begin
      for (int k = 0; k < NUM_CHECKS; k++) begin
        if (chk_off == ADDR_W'(k)) begin
          shadow_q[k]  <= DO;
          written_q[k] <= 1'b1;
        end
      end
    end
  end

  // Verdict for the entry selected by the compare index.
  logic cur_ok;

  // Select the shadow entry under test and compare it to its expected byte.
  always_comb begin
    cur_ok = 1'b0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (cmp_idx_q == IW'(k)) begin
        cur_ok = written_q[k] && (shadow_q[k] == exp_vals[8*k +: 8]);
      end
    end
  end

  // Run / settle / compare / done sequencer with registered result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cycle_cnt_q  <= '0;
      settle_cnt_q <= '0;
      cmp_idx_q    <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      fail_index_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cycle_cnt_q != {CNT_W{1'b1}}) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
          end
          // The marker takes priority over a timeout on the same cycle.
          if (marker_hit) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
          end else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= ST_DONE;
            done_q       <= 1'b1;
            pass_q       <= 1'b0;
            timed_out_q  <= 1'b1;
            fail_index_q <= '1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
            state_q   <= ST_COMPARE;
            cmp_idx_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SW'(1);
          end
        end
        ST_COMPARE: begin
          // Index NUM_CHECKS is reached only when every entry matched.
          if (cmp_idx_q == IW'(NUM_CHECKS)) begin
            state_q      <= ST_DONE;
            done_q       <= 1'b1;
            pass_q       <= 1'b1;
            fail_index_q <= cmp_idx_q;
          end else if (!cur_ok) begin
            state_q      <= ST_DONE;
            done_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_index_q <= cmp_idx_q;
          end else begin
            cmp_idx_q <= cmp_idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_index  = fail_index_q;
  assign cycle_count = cycle_cnt_q;

  // ---------------------------------------------------------------------
  // Trace FIFO
  // ---------------------------------------------------------------------
  logic [ADDR_W+7:0] fifo_mem [TRACE_DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              fifo_empty;
  logic              fifo_full;
  logic              do_pop;
  logic              do_push;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop     = !fifo_empty && trace_ready;
  assign do_push    = WE && (!fifo_full || do_pop);

  // Pointer and overflow next-state.
  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
    overflow_d = overflow_q || (WE && fifo_full && !do_pop);
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; a slot is only read once its pointer marks it valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= {AB, DO};
    end
  end

  assign trace_valid              = !fifo_empty;
  assign {trace_addr, trace_data} = fifo_mem[rd_ptr_q[PW-1:0]];
  assign trace_overflow           = overflow_q;

endmodule

// File: tb/tb_bus_test_monitor.sv
// tb_bus_test_monitor: directed bus traffic with a transaction-level model
// of the harness checked every cycle, plus hand-computed result checks.
module tb_bus_test_monitor;

  localparam int N     = 4;
  localparam int IW    = 3;
  localparam int TO    = 50;
  localparam int S     = 10;
  localparam int DEPTH = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [15:0]         AB;
  logic [7:0]          DO;
  logic                WE;
  logic [7:0]          DI;
  logic [8*N-1:0]      exp_vals;
  logic                done, pass, timed_out;
  logic [IW-1:0]       fail_index;
  logic [31:0]         cycle_count;
  logic                trace_valid, trace_ready;
  logic [15:0]         trace_addr;
  logic [7:0]          trace_data;
  logic                trace_overflow;

  bus_test_monitor #(
    .ADDR_W(16), .RAM_AW(15), .FILL_BYTE(8'hEA), .INIT_FILE(""),
    .MARKER_ADDR(16'h8004), .MARKER_VAL(8'hFF), .CHECK_BASE(16'h8000),
    .NUM_CHECKS(N), .TIMEOUT(TO), .SETTLE_CYCLES(S), .TRACE_DEPTH(DEPTH),
    .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .DI(DI),
    .exp_vals(exp_vals), .done(done), .pass(pass), .timed_out(timed_out),
    .fail_index(fail_index), .cycle_count(cycle_count),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mmem [logic [15:0]];
  logic [7:0]  m_di;
  bit          m_di_known;
  bit          m_live = 0;
  int          m_e;
  int          m_marker;
  bit          m_done, m_pass, m_to;
  logic [IW-1:0] m_fi;
  logic [31:0] m_cnt;
  logic [7:0]  m_sh [N];
  bit          m_wr [N];
  logic [23:0] m_q [$];
  bit          m_ovf;

  function automatic int first_fail();
    for (int k = 0; k < N; k++)
      if (!m_wr[k] || m_sh[k] != exp_vals[8*k +: 8]) return k;
    return N;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_e = 0; m_marker = -1;
      m_done = 0; m_pass = 0; m_to = 0; m_fi = '0; m_cnt = '0;
      m_di = 8'h00; m_di_known = 1;
      m_q.delete(); m_ovf = 0;
      for (int k = 0; k < N; k++) begin m_wr[k] = 0; m_sh[k] = 8'h00; end
    end else if (m_live) begin
      int sz;
      bit pop;
      int off;
      // RAM: read sees the old contents
      if (AB < 16'h8000) begin
        m_di_known = mmem.exists(AB);
        if (m_di_known) m_di = mmem[AB];
        if (WE) mmem[AB] = DO;
      end else begin
        m_di = 8'hEA; m_di_known = 1;
      end
      // trace queue
      sz  = m_q.size();
      pop = (sz > 0) && trace_ready;
      if (pop) void'(m_q.pop_front());
      if (WE) begin
        if (sz < DEPTH || pop) m_q.push_back({AB, DO});
        else m_ovf = 1;
      end
      // run bookkeeping, edges counted from reset release
      m_e++;
      if (!m_done) begin
        if (m_marker < 0) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          if (WE && AB == 16'h8004 && DO == 8'hFF) m_marker = m_e;
          else if (m_cnt == TO) begin
            m_done = 1; m_to = 1; m_pass = 0; m_fi = '1;
          end
        end
        off = int'(AB) - 32'h8000;
        if ((m_marker < 0 || m_e <= m_marker + S) && WE && off >= 0 && off < N) begin
          m_sh[off] = DO; m_wr[off] = 1;
        end
        if (m_marker >= 0 && m_e > m_marker + S) begin
          int fi;
          fi = first_fail();
          if (m_e == m_marker + S + 1 + fi) begin
            m_done = 1; m_pass = (fi == N); m_fi = IW'(fi);
          end
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (m_live) begin
      if (m_di_known) chk("DI", 64'(DI), 64'(m_di));
      chk("done", 64'(done), 64'(m_done));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("timed_out", 64'(timed_out), 64'(m_to));
      chk("fail_index", 64'(fail_index), 64'(m_fi));
      chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
      chk("trace_valid", 64'(trace_valid), 64'(m_q.size() > 0));
      chk("trace_overflow", 64'(trace_overflow), 64'(m_ovf));
      if (m_q.size() > 0) begin
        chk("trace_addr", 64'(trace_addr), 64'(m_q[0][23:8]));
        chk("trace_data", 64'(trace_data), 64'(m_q[0][7:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w);
    AB = a; DO = d; WE = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(16'hC000, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // Bus writes of the LDA/LDX/LDY/STA/STX/STY/ADC program; marker lands on edge 7.
  task automatic prog(input bit ram_wr, input bit skip_8002);
    if (ram_wr) bus(16'h0010, 8'h5A, 1'b1); else bus(16'h0010, 8'h00, 1'b0);
    bus(16'h8000, 8'h42, 1'b1);
    bus(16'h0010, 8'h00, 1'b0);
    chk("ram_read_0010", 64'(DI), 64'h5A);
    bus(16'h8001, 8'h33, 1'b1);
    if (skip_8002) bus(16'hC000, 8'h00, 1'b0); else bus(16'h8002, 8'h24, 1'b1);
    bus(16'h8003, 8'h43, 1'b1);
    bus(16'h8004, 8'hFF, 1'b1);
  endtask

  // Idles until done; returns the edge (since reset release) it was seen on.
  task automatic wait_done(input int start, output int e);
    e = start;
    while (done !== 1'b1 && e < 200) begin
      idle(1);
      e++;
    end
    if (done !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: done never rose within 200 edges");
    end
  endtask

  initial begin
    int e;
    reset = 1'b1; AB = 16'hC000; DO = 8'h00; WE = 1'b0; trace_ready = 1'b0;
    exp_vals = {8'h43, 8'h24, 8'h33, 8'h42};

    // reset state
    idle(2);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_DI", 64'(DI), 64'h0);
    chk("rst_cycle_count", 64'(cycle_count), 64'h0);
    chk("rst_trace_valid", 64'(trace_valid), 64'h0);
    reset = 1'b0;

    // 1: passing program
    trace_ready = 1'b1;
    prog(1'b1, 1'b0);
    wait_done(7, e);
    chk("pass_done_edge", 64'(e), 64'd22);
    chk("pass_pass", 64'(pass), 64'h1);
    chk("pass_fail_index", 64'(fail_index), 64'd4);
    chk("pass_timed_out", 64'(timed_out), 64'h0);
    chk("pass_cycle_count", 64'(cycle_count), 64'd7);
    chk("unmapped_DI", 64'(DI), 64'hEA);

    // 2: byte 3 expected 8'h44 -> fails at index 3
    do_reset();
    exp_vals = {8'h44, 8'h24, 8'h33, 8'h42};
    prog(1'b0, 1'b0);
    wait_done(7, e);
    chk("fail3_done_edge", 64'(e), 64'd21);
    chk("fail3_pass", 64'(pass), 64'h0);
    chk("fail3_fail_index", 64'(fail_index), 64'd3);
    exp_vals = {8'h43, 8'h24, 8'h33, 8'h42};

    // 3: no marker -> timeout
    do_reset();
    wait_done(0, e);
    chk("to_done_edge", 64'(e), 64'd50);
    chk("to_timed_out", 64'(timed_out), 64'h1);
    chk("to_cycle_count", 64'(cycle_count), 64'd50);
    chk("to_fail_index", 64'(fail_index), 64'h7);
    chk("to_pass", 64'(pass), 64'h0);
    idle(3);
    chk("to_count_held", 64'(cycle_count), 64'd50);

    // 4: $8002 never written
    do_reset();
    prog(1'b0, 1'b1);
    wait_done(7, e);
    chk("miss_done_edge", 64'(e), 64'd20);
    chk("miss_pass", 64'(pass), 64'h0);
    chk("miss_fail_index", 64'(fail_index), 64'd2);

    // 5a: 20 writes with consumer stalled -> 16 kept in order, overflow
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) bus(16'h0200 + 16'(i), 8'h10 + 8'(i), 1'b1);
    chk("ovf_set", 64'(trace_overflow), 64'h1);
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 64'(trace_valid), 64'h1);
      chk("drain_addr", 64'(trace_addr), 64'(16'h0200 + 16'(i)));
      chk("drain_data", 64'(trace_data), 64'(8'h10 + 8'(i)));
      idle(1);
    end
    chk("drain_empty", 64'(trace_valid), 64'h0);

    // 5b: full FIFO with push and pop on the same cycle -> no overflow
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus(16'h0300 + 16'(i), 8'(i), 1'b1);
    chk("full_no_ovf", 64'(trace_overflow), 64'h0);
    trace_ready = 1'b1;
    bus(16'h0310, 8'hAA, 1'b1);
    chk("pushpop_no_ovf", 64'(trace_overflow), 64'h0);
    chk("pushpop_head", 64'(trace_addr), 64'h0301);
    trace_ready = 1'b0;
    bus(16'h0311, 8'hBB, 1'b1);
    chk("full_push_ovf", 64'(trace_overflow), 64'h1);

    // 6: reset during SETTLE, then a clean passing run
    do_reset();
    trace_ready = 1'b1;
    prog(1'b0, 1'b0);
    idle(3);
    reset = 1'b1;
    idle(1);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_cycle_count", 64'(cycle_count), 64'h0);
    chk("midrst_fail_index", 64'(fail_index), 64'h0);
    chk("midrst_trace_valid", 64'(trace_valid), 64'h0);
    chk("midrst_overflow", 64'(trace_overflow), 64'h0);
    reset = 1'b0;
    prog(1'b0, 1'b0);
    wait_done(7, e);
    chk("rerun_done_edge", 64'(e), 64'd22);
    chk("rerun_pass", 64'(pass), 64'h1);
    chk("rerun_fail_index", 64'(fail_index), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
